// File: rtl/copro_bcd_unit.sv
// Multi-cycle BCD arithmetic unit for the CV-X-IF example coprocessor.
// BIN2BCD runs an iterative double-dabble (one bit per cycle); BCDADD/BCDSUB
// and illegal ops resolve at the accept edge. A single response buffer with
// valid/ready back-pressure carries the result and the pass-through tags.
module copro_bcd_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned HartIdWidth = 1,
  parameter int unsigned IdWidth     = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [1:0]             req_op_i,
  input  logic [XLEN-1:0]        req_rs1_i,
  input  logic [XLEN-1:0]        req_rs2_i,
  input  logic [HartIdWidth-1:0] req_hartid_i,
  input  logic [IdWidth-1:0]     req_id_i,
  input  logic [4:0]             req_rd_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [XLEN-1:0]        resp_result_o,
  output logic [HartIdWidth-1:0] resp_hartid_o,
  output logic [IdWidth-1:0]     resp_id_o,
  output logic [4:0]             resp_rd_o,
  output logic                   resp_we_o,
  output logic                   resp_ovf_o,
  output logic                   resp_inv_o,
  output logic                   busy_o
);

  localparam int unsigned NumDigits = XLEN / 4;
  localparam int unsigned CntW      = $clog2(XLEN);
  localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);

  localparam logic [1:0] OpBin2Bcd = 2'b00;
  localparam logic [1:0] OpBcdAdd  = 2'b01;
  localparam logic [1:0] OpBcdSub  = 2'b10;

  typedef enum logic [1:0] {StIdle, StConv, StResp} state_e;

  state_e                 state_q, state_d;
  logic [XLEN-1:0]        bin_q, bin_d;
  logic [XLEN-1:0]        acc_q, acc_d;
  logic                   acc_ovf_q, acc_ovf_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]        result_q, result_d;
  logic [HartIdWidth-1:0] hartid_q, hartid_d;
  logic [IdWidth-1:0]     id_q, id_d;
  logic [4:0]             rd_q, rd_d;
  logic                   we_q, we_d;
  logic                   ovf_q, ovf_d;
  logic                   inv_q, inv_d;

  logic                   accept;

  // Combinational BCD add/sub over all digits plus operand digit validity.
  logic [XLEN-1:0] add_res, sub_res;
  logic            add_carry, sub_borrow, opnd_inv;
  always_comb begin
    logic [4:0] s;
    logic [4:0] t;
    logic [3:0] xd;
    logic [3:0] yd;
    add_res    = '0;
    sub_res    = '0;
    add_carry  = 1'b0;
    sub_borrow = 1'b0;
    opnd_inv   = 1'b0;
    s          = '0;
    t          = '0;
    xd         = '0;
    yd         = '0;
    for (int i = 0; i < NumDigits; i++) begin
      xd = req_rs1_i[i*4 +: 4];
      yd = req_rs2_i[i*4 +: 4];
      if (xd > 4'd9 || yd > 4'd9) opnd_inv = 1'b1;
      s = {1'b0, xd} + {1'b0, yd} + {4'b0, add_carry};
      if (s >= 5'd10) begin
        s         = s - 5'd10;
        add_carry = 1'b1;
      end else begin
        add_carry = 1'b0;
      end
      add_res[i*4 +: 4] = s[3:0];
      // Borrow when x < y + b; otherwise the plain difference fits a digit.
      if ({1'b0, xd} < ({1'b0, yd} + {4'b0, sub_borrow})) begin
        t          = {1'b0, xd} + 5'd10 - {1'b0, yd} - {4'b0, sub_borrow};
        sub_borrow = 1'b1;
      end else begin
        t          = {1'b0, xd} - {1'b0, yd} - {4'b0, sub_borrow};
        sub_borrow = 1'b0;
      end
      sub_res[i*4 +: 4] = t[3:0];
    end
  end

  // One double-dabble step: add-3 correction then shift {acc, bin} left.
  logic [XLEN-1:0] acc_adj, acc_sh, bin_sh;
  logic            acc_out;
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < NumDigits; i++) begin
      if (acc_q[i*4 +: 4] >= 4'd5) acc_adj[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
    end
    acc_out = acc_adj[XLEN-1];
    acc_sh  = {acc_adj[XLEN-2:0], bin_q[XLEN-1]};
    bin_sh  = {bin_q[XLEN-2:0], 1'b0};
  end

  assign req_ready_o = !rst_i && !flush_i &&
                       ((state_q == StIdle) || ((state_q == StResp) && resp_ready_i));
  assign accept      = req_valid_i && req_ready_o;

  // Next-state logic: iterate, consume, accept (accept overrides consume), flush last.
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    acc_d     = acc_q;
    acc_ovf_d = acc_ovf_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    hartid_d  = hartid_q;
    id_d      = id_q;
    rd_d      = rd_q;
    we_d      = we_q;
    ovf_d     = ovf_q;
    inv_d     = inv_q;

    unique case (state_q)
      StConv: begin
        bin_d     = bin_sh;
        acc_d     = acc_sh;
        acc_ovf_d = acc_ovf_q | acc_out;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d  = StResp;
          result_d = acc_sh;
          ovf_d    = acc_ovf_q | acc_out;
          we_d     = 1'b1;
          inv_d    = 1'b0;
        end
      end
      StResp: begin
        if (resp_ready_i) state_d = StIdle;
      end
      default: ;
    endcase

    if (accept) begin
      hartid_d = req_hartid_i;
      id_d     = req_id_i;
      rd_d     = req_rd_i;
      if (req_op_i == OpBin2Bcd) begin
        bin_d     = req_rs1_i;
        acc_d     = '0;
        acc_ovf_d = 1'b0;
        cnt_d     = '0;
        state_d   = StConv;
      end else begin
        state_d = StResp;
        if (req_op_i == OpBcdAdd && !opnd_inv) begin
          result_d = add_res;
          ovf_d    = add_carry;
          we_d     = 1'b1;
          inv_d    = 1'b0;
        end else if (req_op_i == OpBcdSub && !opnd_inv) begin
          result_d = sub_res;
          ovf_d    = sub_borrow;
          we_d     = 1'b1;
          inv_d    = 1'b0;
        end else begin
          // Illegal op or non-BCD operand digit.
          result_d = '0;
          ovf_d    = 1'b0;
          we_d     = 1'b0;
          inv_d    = 1'b1;
        end
      end
    end

    if (flush_i) state_d = StIdle;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      bin_q     <= '0;
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
      hartid_q  <= '0;
      id_q      <= '0;
      rd_q      <= '0;
      we_q      <= 1'b0;
      ovf_q     <= 1'b0;
      inv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      acc_q     <= acc_d;
      acc_ovf_q <= acc_ovf_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      hartid_q  <= hartid_d;
      id_q      <= id_d;
      rd_q      <= rd_d;
      we_q      <= we_d;
      ovf_q     <= ovf_d;
      inv_q     <= inv_d;
    end
  end

  assign resp_valid_o  = (state_q == StResp);
  assign busy_o        = (state_q != StIdle);
  assign resp_result_o = result_q;
  assign resp_hartid_o = hartid_q;
  assign resp_id_o     = id_q;
  assign resp_rd_o     = rd_q;
  assign resp_we_o     = we_q;
  assign resp_ovf_o    = ovf_q;
  assign resp_inv_o    = inv_q;

endmodule
